// File: rtl/memory_game_pkg.sv
// Shared encodings for the memory game sequencer: FSM states, card-memory
// write codes, registered control-output bundle and default delays.
package memory_game_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] S_MENU    = 5'd0;
    localparam logic [STATE_W-1:0] S_COMPUTE = 5'd1;
    localparam logic [STATE_W-1:0] S_UPD1    = 5'd2;
    localparam logic [STATE_W-1:0] S_WAIT1   = 5'd3;
    localparam logic [STATE_W-1:0] S_CLICK1  = 5'd4;
    localparam logic [STATE_W-1:0] S_REV1    = 5'd5;
    localparam logic [STATE_W-1:0] S_UPD2    = 5'd6;
    localparam logic [STATE_W-1:0] S_WAIT2   = 5'd7;
    localparam logic [STATE_W-1:0] S_CLICK2  = 5'd8;
    localparam logic [STATE_W-1:0] S_REV2    = 5'd9;
    localparam logic [STATE_W-1:0] S_UPD3    = 5'd10;
    localparam logic [STATE_W-1:0] S_COMPARE = 5'd11;
    localparam logic [STATE_W-1:0] S_HOLD    = 5'd12;
    localparam logic [STATE_W-1:0] S_COVER_A = 5'd13;
    localparam logic [STATE_W-1:0] S_COVER_B = 5'd14;
    localparam logic [STATE_W-1:0] S_DEACT_A = 5'd15;
    localparam logic [STATE_W-1:0] S_DEACT_B = 5'd16;
    localparam logic [STATE_W-1:0] S_END     = 5'd17;

    localparam logic [1:0] WR_IDLE   = 2'b00;
    localparam logic [1:0] WR_COVER  = 2'b01;
    localparam logic [1:0] WR_DEACT  = 2'b10;
    localparam logic [1:0] WR_REVEAL = 2'b11;

    localparam int DEF_WAIT_SHORT_CYC = 13_000_000;
    localparam int DEF_WAIT_LONG_CYC  = 32_500_000;

    typedef struct packed {
        logic       start_butt_en;
        logic       compute_colors_en;
        logic       stopwatch_en;
        logic       stopwatch_disable;
        logic       update_cards_en;
        logic       wait_for_click_en;
        logic       write_card_en;
        logic [1:0] write_card_state;
        logic       end_screen_en;
    } ctrl_out_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/memory_game_ctrl_timer.sv
// Delay timer for the WAIT and HOLD states: cleared on load, counts up while
// enabled and flags done during the last cycle of the interval.
module game_delay_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = en && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (en && !done)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game sequencer: menu, shuffle, two-card reveal, compare, cover or
// deactivate, end screen. All control outputs are registered images of state.
//
// state   | meaning
// MENU    | wait for start button
// COMPUTE | shuffle colours, start stopwatch, clear score
// UPD1-3  | redraw request
// WAIT1/2 | click debounce delay
// CLICK1/2| wait for first / second legal card click
// REV1/2  | reveal first / second card
// COMPARE | count move, record match
// HOLD    | show both cards
// COVER_* | cover both cards (addr0 then addr1)
// DEACT_* | deactivate both cards (addr0 then addr1)
// END     | end screen until abort or reset
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int NUM_PAIRS      = 6,
    parameter int ADDR_W         = 4,
    parameter int COLOR_W        = 12,
    parameter int WAIT_SHORT_CYC = DEF_WAIT_SHORT_CYC,
    parameter int WAIT_LONG_CYC  = DEF_WAIT_LONG_CYC,
    parameter int MOVE_W         = 10,
    localparam int PAIRS_W       = $clog2(NUM_PAIRS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_butt_pressed,
    input  logic               compute_done,
    input  logic               card_pressed,
    input  logic [ADDR_W-1:0]  card_clicked_address,
    input  logic [COLOR_W-1:0] card_clicked_color,
    input  logic               abort,
    output logic               start_butt_en,
    output logic               compute_colors_en,
    output logic               stopwatch_en,
    output logic               stopwatch_disable,
    output logic               update_cards_en,
    output logic               wait_for_click_en,
    output logic               write_card_en,
    output logic [1:0]         write_card_state,
    output logic [ADDR_W-1:0]  write_card_address,
    output logic               end_screen_en,
    output logic               click_rejected,
    output logic [MOVE_W-1:0]  move_count,
    output logic [PAIRS_W-1:0] pairs_left
);
    localparam int CNT_W = max_int(1, $clog2(max_int(WAIT_SHORT_CYC, WAIT_LONG_CYC)));
    localparam logic [CNT_W-1:0]   SHORT_LAST = CNT_W'(WAIT_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0]   LONG_LAST  = CNT_W'(WAIT_LONG_CYC - 1);
    localparam logic [PAIRS_W-1:0] PAIRS_INIT = PAIRS_W'(NUM_PAIRS);
    localparam logic [MOVE_W-1:0]  MOVE_MAX   = {MOVE_W{1'b1}};
    localparam logic [ADDR_W:0]    CARD_LIMIT = (ADDR_W + 1)'(2 * NUM_PAIRS);

    logic [STATE_W-1:0]      state_q, state_d;
    logic [ADDR_W-1:0]       addr0_q, addr0_d, addr1_q, addr1_d, wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0]      color0_q, color0_d, color1_q, color1_d;
    logic [(1<<ADDR_W)-1:0]  matched_q, matched_d;
    logic [PAIRS_W-1:0]      pairs_left_q, pairs_left_d;
    logic [MOVE_W-1:0]       move_count_q, move_count_d;
    logic                    click_rejected_q, click_rejected_d;
    ctrl_out_t               out_q, out_d;
    logic                    tmr_en, tmr_done, click_bad, colors_eq;
    logic [CNT_W-1:0]        tmr_last;

    assign tmr_en    = state_q inside {S_WAIT1, S_WAIT2, S_HOLD};
    assign tmr_last  = (state_q == S_HOLD) ? LONG_LAST : SHORT_LAST;
    assign colors_eq = (color0_q == color1_q);
    // Matched bitmap spans the full address space so out-of-range clicks index safely.
    assign click_bad = ({1'b0, card_clicked_address} >= CARD_LIMIT)
                    || matched_q[card_clicked_address]
                    || ((state_q == S_CLICK2) && (card_clicked_address == addr0_q));

    game_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (state_d != state_q),
        .en   (tmr_en),
        .last (tmr_last),
        .done (tmr_done)
    );

    always_comb begin
        state_d          = state_q;
        addr0_d          = addr0_q;
        addr1_d          = addr1_q;
        color0_d         = color0_q;
        color1_d         = color1_q;
        matched_d        = matched_q;
        pairs_left_d     = pairs_left_q;
        move_count_d     = move_count_q;
        click_rejected_d = 1'b0;
        case (state_q)
            S_MENU:    if (start_butt_pressed) state_d = S_COMPUTE;
            S_COMPUTE: begin
                pairs_left_d = PAIRS_INIT;
                move_count_d = '0;
                matched_d    = '0;
                if (compute_done) state_d = S_UPD1;
            end
            S_UPD1:    state_d = (pairs_left_q == '0) ? S_END : S_WAIT1;
            S_WAIT1:   if (tmr_done) state_d = S_CLICK1;
            S_CLICK1:  if (card_pressed) begin
                if (click_bad) click_rejected_d = 1'b1;
                else begin
                    addr0_d  = card_clicked_address;
                    color0_d = card_clicked_color;
                    state_d  = S_REV1;
                end
            end
            S_REV1:    state_d = S_UPD2;
            S_UPD2:    state_d = S_WAIT2;
            S_WAIT2:   if (tmr_done) state_d = S_CLICK2;
            S_CLICK2:  if (card_pressed) begin
                if (click_bad) click_rejected_d = 1'b1;
                else begin
                    addr1_d  = card_clicked_address;
                    color1_d = card_clicked_color;
                    state_d  = S_REV2;
                end
            end
            S_REV2:    state_d = S_UPD3;
            S_UPD3:    state_d = S_COMPARE;
            S_COMPARE: begin
                if (move_count_q != MOVE_MAX) move_count_d = move_count_q + MOVE_W'(1);
                if (colors_eq) begin
                    pairs_left_d       = pairs_left_q - PAIRS_W'(1);
                    matched_d[addr0_q] = 1'b1;
                    matched_d[addr1_q] = 1'b1;
                end
                state_d = S_HOLD;
            end
            S_HOLD:    if (tmr_done) state_d = colors_eq ? S_DEACT_A : S_COVER_A;
            S_COVER_A: state_d = S_COVER_B;
            S_DEACT_A: state_d = S_DEACT_B;
            S_COVER_B, S_DEACT_B: state_d = S_UPD1;
            S_END:     state_d = S_END;
            default:   state_d = S_MENU;
        endcase
        if (abort && (state_q != S_MENU)) begin
            state_d          = S_MENU;
            pairs_left_d     = PAIRS_INIT;
            move_count_d     = '0;
            matched_d        = '0;
            click_rejected_d = 1'b0;
        end
    end

    always_comb begin
        out_d     = '0;
        wr_addr_d = '0;
        case (state_q)
            S_MENU:    out_d.start_butt_en = 1'b1;
            S_COMPUTE: begin
                out_d.compute_colors_en = 1'b1;
                out_d.stopwatch_en      = 1'b1;
            end
            S_UPD1, S_UPD2, S_UPD3: out_d.update_cards_en   = 1'b1;
            S_CLICK1, S_CLICK2:     out_d.wait_for_click_en = 1'b1;
            S_REV1, S_REV2: begin
                out_d.write_card_en    = 1'b1;
                out_d.write_card_state = WR_REVEAL;
                wr_addr_d = (state_q == S_REV1) ? addr0_q : addr1_q;
            end
            S_COVER_A, S_COVER_B: begin
                out_d.write_card_en    = 1'b1;
                out_d.write_card_state = WR_COVER;
                wr_addr_d = (state_q == S_COVER_A) ? addr0_q : addr1_q;
            end
            S_DEACT_A, S_DEACT_B: begin
                out_d.write_card_en    = 1'b1;
                out_d.write_card_state = WR_DEACT;
                wr_addr_d = (state_q == S_DEACT_A) ? addr0_q : addr1_q;
            end
            S_END: begin
                out_d.stopwatch_disable = 1'b1;
                out_d.end_screen_en     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_MENU;
            addr0_q          <= '0;
            addr1_q          <= '0;
            color0_q         <= '0;
            color1_q         <= '0;
            matched_q        <= '0;
            pairs_left_q     <= PAIRS_INIT;
            move_count_q     <= '0;
            click_rejected_q <= 1'b0;
            out_q            <= '0;
            wr_addr_q        <= '0;
        end else begin
            state_q          <= state_d;
            addr0_q          <= addr0_d;
            addr1_q          <= addr1_d;
            color0_q         <= color0_d;
            color1_q         <= color1_d;
            matched_q        <= matched_d;
            pairs_left_q     <= pairs_left_d;
            move_count_q     <= move_count_d;
            click_rejected_q <= click_rejected_d;
            out_q            <= out_d;
            wr_addr_q        <= wr_addr_d;
        end
    end

    assign start_butt_en      = out_q.start_butt_en;
    assign compute_colors_en  = out_q.compute_colors_en;
    assign stopwatch_en       = out_q.stopwatch_en;
    assign stopwatch_disable  = out_q.stopwatch_disable;
    assign update_cards_en    = out_q.update_cards_en;
    assign wait_for_click_en  = out_q.wait_for_click_en;
    assign write_card_en      = out_q.write_card_en;
    assign write_card_state   = out_q.write_card_state;
    assign write_card_address = wr_addr_q;
    assign end_screen_en      = out_q.end_screen_en;
    assign click_rejected     = click_rejected_q;
    assign move_count         = move_count_q;
    assign pairs_left         = pairs_left_q;
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: linear game scenarios with a write
// scoreboard checked at every card-memory write strobe.
module tb_memory_game_ctrl;
    import memory_game_pkg::*;

    localparam int NP = 2, AW = 4, CW = 12, WS = 3, WL = 5, MW = 10;
    localparam int PW = $clog2(NP + 1);

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start_butt_pressed = 1'b0, compute_done = 1'b0, card_pressed = 1'b0, abort = 1'b0;
    logic [AW-1:0] card_clicked_address = '0;
    logic [CW-1:0] card_clicked_color = '0;
    logic          start_butt_en, compute_colors_en, stopwatch_en, stopwatch_disable;
    logic          update_cards_en, wait_for_click_en, write_card_en, end_screen_en, click_rejected;
    logic [1:0]    write_card_state;
    logic [AW-1:0] write_card_address;
    logic [MW-1:0] move_count;
    logic [PW-1:0] pairs_left;

    memory_game_ctrl #(
        .NUM_PAIRS(NP), .ADDR_W(AW), .COLOR_W(CW),
        .WAIT_SHORT_CYC(WS), .WAIT_LONG_CYC(WL), .MOVE_W(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_butt_pressed(start_butt_pressed), .compute_done(compute_done),
        .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
        .card_clicked_color(card_clicked_color), .abort(abort),
        .start_butt_en(start_butt_en), .compute_colors_en(compute_colors_en),
        .stopwatch_en(stopwatch_en), .stopwatch_disable(stopwatch_disable),
        .update_cards_en(update_cards_en), .wait_for_click_en(wait_for_click_en),
        .write_card_en(write_card_en), .write_card_state(write_card_state),
        .write_card_address(write_card_address), .end_screen_en(end_screen_en),
        .click_rejected(click_rejected), .move_count(move_count), .pairs_left(pairs_left)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    typedef struct packed {
        logic [1:0]    st;
        logic [AW-1:0] addr;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (write_card_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_en", write_card_en, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_state", write_card_state, mon_e.st);
                check("write_addr", write_card_address, mon_e.addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return wait_for_click_en;
            1: return update_cards_en;
            2: return end_screen_en;
            3: return write_card_en && (write_card_state == WR_COVER);
            4: return write_card_en && (write_card_state == WR_DEACT);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string tag, output int n);
        n = 0;
        while (sig(sel) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, sig(sel), 1'b1);
    endtask

    task automatic click(input logic [AW-1:0] a, input logic [CW-1:0] c);
        card_pressed         = 1'b1;
        card_clicked_address = a;
        card_clicked_color   = c;
        tick();
        card_pressed         = 1'b0;
    endtask

    task automatic new_game();
        start_butt_pressed = 1'b1;
        tick();
        start_butt_pressed = 1'b0;
        compute_done       = 1'b1;
        tick();
        compute_done       = 1'b0;
    endtask

    function automatic logic [10:0] flag_vec();
        return {start_butt_en, compute_colors_en, stopwatch_en, stopwatch_disable, update_cards_en,
                wait_for_click_en, write_card_en, write_card_state, end_screen_en, click_rejected};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state and start-up sequence
        #12;
        check("reset_flags", flag_vec(), 11'd0);
        check("reset_wr_addr", write_card_address, 0);
        check("reset_pairs_left", pairs_left, NP);
        check("reset_move_count", move_count, 0);
        rst_n = 1'b1;
        tick();
        check("menu_start_en", start_butt_en, 1'b1);
        start_butt_pressed = 1'b1;
        tick();
        start_butt_pressed = 1'b0;
        check("start_en_lag", start_butt_en, 1'b1);
        check("compute_not_yet", compute_colors_en, 1'b0);
        tick();
        check("start_en_drop", start_butt_en, 1'b0);
        check("compute_en", compute_colors_en, 1'b1);
        check("stopwatch_en", stopwatch_en, 1'b1);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick();
        check("upd1_pulse", update_cards_en, 1'b1);
        check("pairs_left_init", pairs_left, NP);
        // Clicks and start presses during WAIT1 are ignored
        start_butt_pressed = 1'b1;
        card_pressed = 1'b1;
        card_clicked_address = 4'd7;
        tick();
        start_butt_pressed = 1'b0;
        card_pressed = 1'b0;
        check("no_reject_in_wait", click_rejected, 1'b0);
        wait_sig(0, "click1_reached", n);
        check("wait1_len", n, WS);

        // Turn 1: match at 0 and 2
        exp_q.push_back('{WR_REVEAL, 4'd0});
        click(4'd0, 12'hF00);
        tick();
        wait_sig(0, "click2_reached", n);
        exp_q.push_back('{WR_REVEAL, 4'd2});
        exp_q.push_back('{WR_DEACT, 4'd0});
        exp_q.push_back('{WR_DEACT, 4'd2});
        click(4'd2, 12'hF00);
        wait_sig(4, "deact_reached", n);
        check("hold_len", n, WL + 4);
        tick();
        check("deact_second", sig(4), 1'b1);
        check("pairs_after_match", pairs_left, NP - 1);
        check("moves_after_t1", move_count, 1);

        // Turn 2: mismatch at 1 and 3
        wait_sig(0, "t2_click1", n);
        exp_q.push_back('{WR_REVEAL, 4'd1});
        click(4'd1, 12'h0F0);
        tick();
        wait_sig(0, "t2_click2", n);
        exp_q.push_back('{WR_REVEAL, 4'd3});
        exp_q.push_back('{WR_COVER, 4'd1});
        exp_q.push_back('{WR_COVER, 4'd3});
        click(4'd3, 12'h00F);
        wait_sig(3, "cover_reached", n);
        tick();
        check("cover_second", sig(3), 1'b1);
        check("pairs_after_mismatch", pairs_left, NP - 1);
        check("moves_after_t2", move_count, 2);

        // Turn 3: rejected clicks, then the final pair
        wait_sig(0, "t3_click1", n);
        click(4'd0, 12'hF00);
        check("rej_matched", click_rejected, 1'b1);
        check("stay_click1", wait_for_click_en, 1'b1);
        tick();
        check("rej_pulse_end", click_rejected, 1'b0);
        click(4'd7, 12'hF00);
        check("rej_out_of_range", click_rejected, 1'b1);
        exp_q.push_back('{WR_REVEAL, 4'd1});
        click(4'd1, 12'h0F0);
        check("accept_valid", click_rejected, 1'b0);
        tick();
        wait_sig(0, "t3_click2", n);
        click(4'd1, 12'h0F0);
        check("rej_same_card", click_rejected, 1'b1);
        click(4'd2, 12'hF00);
        check("rej_matched2", click_rejected, 1'b1);
        check("stay_click2", wait_for_click_en, 1'b1);
        exp_q.push_back('{WR_REVEAL, 4'd3});
        exp_q.push_back('{WR_DEACT, 4'd1});
        exp_q.push_back('{WR_DEACT, 4'd3});
        click(4'd3, 12'h0F0);
        wait_sig(2, "end_reached", n);
        check("end_sw_disable", stopwatch_disable, 1'b1);
        check("pairs_final", pairs_left, 0);
        check("moves_final", move_count, 3);
        repeat (20) tick();
        check("end_hold_screen", end_screen_en, 1'b1);
        check("end_hold_sw", stopwatch_disable, 1'b1);

        // Abort from END
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_end_moves", move_count, 0);
        check("abort_end_pairs", pairs_left, NP);
        tick();
        check("abort_end_menu", start_butt_en, 1'b1);
        check("abort_end_screen_off", end_screen_en, 1'b0);

        // Abort during HOLD: no cover writes follow
        new_game();
        wait_sig(0, "g2_click1", n);
        exp_q.push_back('{WR_REVEAL, 4'd0});
        click(4'd0, 12'hF00);
        tick();
        wait_sig(0, "g2_click2", n);
        exp_q.push_back('{WR_REVEAL, 4'd2});
        click(4'd2, 12'h00F);
        repeat (4) tick();
        check("g2_move_in_hold", move_count, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_hold_moves", move_count, 0);
        check("abort_hold_pairs", pairs_left, NP);
        repeat (12) tick();
        check("abort_hold_menu", start_butt_en, 1'b1);

        // Reset in the middle of the cover pair
        new_game();
        wait_sig(0, "g3_click1", n);
        exp_q.push_back('{WR_REVEAL, 4'd0});
        click(4'd0, 12'hF00);
        tick();
        wait_sig(0, "g3_click2", n);
        exp_q.push_back('{WR_REVEAL, 4'd2});
        exp_q.push_back('{WR_COVER, 4'd0});
        click(4'd2, 12'h00F);
        wait_sig(3, "g3_cover", n);
        check("g3_move", move_count, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_flags", flag_vec(), 11'd0);
        check("async_reset_move", move_count, 0);
        check("async_reset_pairs", pairs_left, NP);
        #1;
        rst_n = 1'b1;
        tick();
        check("reset_menu", start_butt_en, 1'b1);
        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
